// File: rtl/serial_sched_pkg.sv
// Shared types and constants for the serial TX scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sched_pkg;

    // Frame sequencer states; ST_PARITY is only reachable when parity is built in.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ID     = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    // Serial line levels.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Number of bit periods in one frame: start + id + data + optional parity + stop.
    function automatic int frame_bits(input int id_w, input int data_w, input bit parity);
        return 2 + id_w + data_w + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Round-robin requester picker: first set req bit after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: grant is only produced while enable is high; no state held here.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);

    logic [IW-1:0] w_pick_lo;
    logic [IW-1:0] w_pick_hi;
    logic          w_found_hi;

    // Lowest set bit overall, and lowest set bit strictly above the last grant;
    // the latter wins so the search order starts at last_grant+1.
    always_comb begin
        w_pick_lo  = '0;
        w_pick_hi  = '0;
        w_found_hi = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick_lo = IW'(i);
            end
            if (req[i] && (i > int'(last_grant))) begin
                w_pick_hi  = IW'(i);
                w_found_hi = 1'b1;
            end
        end
    end

    assign any_req   = |req;
    assign grant_idx = w_found_hi ? w_pick_hi : w_pick_lo;
    assign grant     = (enable && any_req) ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

endmodule

// File: rtl/serial_tx_scheduler.sv
// Arbitrates N_REQ channels onto one serial line: start, ID, data, [parity], stop, LSB first.
// Latency: word accepted in cycle t drives the start bit from t+1; BAUD_DIV clocks per bit.
// Backpressure: req_ready pulses only in IDLE; words wait in the channel FIFOs meanwhile.
// Optional parity bit built in when SERIAL_TX_PARITY_EN is defined.
module serial_tx_scheduler
    import serial_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int BAUD_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      serial_tx,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id
);

    localparam int ID_W   = $clog2(N_REQ);
    localparam int PAY_W  = ID_W + DATA_W;      // ID and data leave as one LSB-first stream
    localparam int CNT_W  = $clog2(PAY_W);
    localparam int BAUD_W = $clog2(BAUD_DIV);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_nxt;
    logic [PAY_W-1:0]    r_shift;
    logic [PAY_W-1:0]    w_shift_nxt;
    logic                r_tx;
    logic                w_tx_nxt;
    logic                w_load;
    logic                w_baud_end;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_last_grant;
    logic [N_REQ-1:0]    w_arb_grant;
    logic [ID_W-1:0]     w_arb_idx;
    logic                w_any_req;
    logic [DATA_W-1:0]   w_sel_data;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity;
`endif

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .enable     (r_state == ST_IDLE),
        .grant      (w_arb_grant),
        .grant_idx  (w_arb_idx),
        .any_req    (w_any_req)
    );

    assign w_sel_data = req_data[w_arb_idx*DATA_W +: DATA_W];
    assign w_baud_end = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));

    // Next-state, counters and next line level; the line is registered so every
    // bit starts on the clock edge that enters its bit period.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_load      = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_nxt = w_baud_end ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = LINE_IDLE;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (w_any_req) begin
                    w_load      = 1'b1;
                    w_shift_nxt = {w_sel_data, w_arb_idx};
                    w_state_nxt = ST_START;
                    w_tx_nxt    = START_BIT;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_ID;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_ID: begin
                if (w_baud_end) begin
                    w_shift_nxt = r_shift >> 1;
                    w_tx_nxt    = r_shift[1];
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == CNT_W'(ID_W - 1)) begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == CNT_W'(PAY_W - 1)) begin
                        w_bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = STOP_BIT;
`endif
                    end else begin
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = STOP_BIT;
                end
            end
`endif
            ST_STOP: begin
                if (w_baud_end) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = LINE_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = LINE_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
            end
        endcase
    end

    // Sequencer state, counters, shift register and registered line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= LINE_IDLE;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Grant bookkeeping; the pointer resets to N_REQ-1 so requester 0 leads after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
        end else if (w_load) begin
            r_grant_id   <= w_arb_idx;
            r_last_grant <= w_arb_idx;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    // Even parity over ID and data, captured with the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^{w_sel_data, w_arb_idx};
        end
    end
`endif

    assign req_ready = w_arb_grant;
    assign serial_tx = r_tx;
    assign busy      = (r_state != ST_IDLE);
    assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Self-checking bench for serial_tx_scheduler (N_REQ=4, DATA_W=8, BAUD_DIV=4).
// Frames are decoded off the line and compared with a scoreboard of expected words.
// Honours SERIAL_TX_PARITY_EN for the expected frame format.
module tb_serial_tx_scheduler;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int BAUD = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB     = 2 + 2 + DW + P;
    localparam int PERIOD = FB * BAUD + 1;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              serial_tx;
    logic              busy;
    logic [1:0]        grant_id;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];
    int   start_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_id;
    } vec_t;
    vec_t vecs[9];

    serial_tx_scheduler #(
        .N_REQ    (NR),
        .DATA_W   (DW),
        .BAUD_DIV (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .serial_tx (serial_tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [FB-1:0] mk_frame(input logic [1:0] id, input logic [7:0] d);
        logic [FB-1:0] f;
        f       = '0;
        f[0]    = 1'b0;
        f[2:1]  = id;
        f[10:3] = d;
`ifdef SERIAL_TX_PARITY_EN
        f[11]   = ^{id, d};
`endif
        f[FB-1] = 1'b1;
        return f;
    endfunction

    // Called at a negedge with the DUT idle: offer v/d, expect exp_id taken this cycle.
    task automatic do_frame(input logic [3:0] v, input logic [31:0] d, input int exp_id, input bit push);
        exp_t e;
        req_valid = v;
        req_data  = d;
        #1;
        check("req_ready_onehot", req_ready, 4'b0001 << exp_id);
        if (push) begin
            e.id   = exp_id[1:0];
            e.data = d[exp_id*8 +: 8];
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        check("busy_after_accept", busy, 1);
        check("start_bit_t1", serial_tx, 0);
        check("grant_id", grant_id, exp_id);
        check("ready_low_busy", req_ready, 0);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("idle_timeout", busy, 0);
    endtask

    // Line monitor: samples every clock of every bit, requires each bit to hold
    // for its whole period, and compares the frame against the scoreboard.
    initial begin : monitor
        logic [FB-1:0] bits;
        logic          stable;
        logic          aborted;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst && serial_tx === 1'b0) begin
                start_q.push_back(cyc);
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < FB; k++) begin
                    for (int c = 0; c < BAUD; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c == 0) bits[k] = serial_tx;
                        else if (serial_tx !== bits[k]) stable = 1'b0;
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    check("bit_stable", stable, 1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got frame 0x%0h, expected no frame", bits);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", bits, mk_frame(e.id, e.data));
                    end
                end
            end
        end
    end

    initial begin : stim
        int   cnt;
        int   sz0;
        int   bad;
        bit   found;
        int   ord[5];
        exp_t e;
        logic [31:0] d;

        // {valid, packed data {d3,d2,d1,d0}, expected grant}; grants follow the
        // round-robin pointer left by the previous row.
        vecs[0] = '{4'b0001, 32'h112233A5, 0};
        vecs[1] = '{4'b0110, 32'h44550366, 1};
        vecs[2] = '{4'b0110, 32'h77C89900, 2};
        vecs[3] = '{4'b0101, 32'h0F1E2D3C, 0};
        vecs[4] = '{4'b0101, 32'hF0E1D2C3, 2};
        vecs[5] = '{4'b1000, 32'h5A000000, 3};
        vecs[6] = '{4'b1111, 32'h01020304, 0};
        vecs[7] = '{4'b0011, 32'hFFFF8081, 1};
        vecs[8] = '{4'b1100, 32'h96690000, 2};

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_serial_tx", serial_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: back-to-back single-requester frames.
        for (int v = 0; v < 9; v++) begin
            check("idle_line_high", serial_tx, 1);
            do_frame(vecs[v].valid, vecs[v].data, vecs[v].exp_id, 1'b1);
            cnt = 1;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (busy) cnt++;
                else break;
            end
            check("busy_length", cnt, FB * BAUD);
        end

        // All requesters held valid after reset: grants rotate 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        d   = 32'hDEADBEEF;
        ord = '{0, 1, 2, 3, 0};
        for (int n = 0; n < 5; n++) begin
            e.id   = ord[n][1:0];
            e.data = d[ord[n]*8 +: 8];
            exp_q.push_back(e);
        end
        sz0       = start_q.size();
        req_data  = d;
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            found = 1'b0;
            for (int i = 0; i < 150; i++) begin
                #1;
                if (req_ready != 0) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("accept_seen", found, 1);
            check("rr_ready", req_ready, 4'b0001 << ord[n]);
            @(negedge clk);
            if (n == 4) req_valid = '0;
            #1;
            check("rr_grant_id", grant_id, ord[n]);
        end
        wait_idle();
        check("rr_frame_count", start_q.size() - sz0, 5);
        for (int k = 0; k < 4; k++) begin
            if (sz0 + k + 1 < start_q.size())
                check("frame_period", start_q[sz0+k+1] - start_q[sz0+k], PERIOD);
        end

        // Short valid pulse mid-frame must not be accepted or queued.
        @(negedge clk);
        do_frame(4'b0001, 32'h000000E7, 0, 1'b1);
        repeat (10) @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("no_ready_midframe", req_ready, 0);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            #1;
            if (serial_tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000) bad++;
        end
        check("quiet_after_pulse", bad, 0);

        // Abort during data bit 3 (a 0 for 0xA5), then the pointer must be back at reset.
        @(negedge clk);
        do_frame(4'b0001, 32'h000000A5, 0, 1'b0);
        repeat (25) @(negedge clk);
        #1;
        check("data_bit3_low", serial_tx, 0);
        #1;
        rst = 1'b1;
        #1;
        check("abort_tx_high", serial_tx, 1);
        check("abort_busy_low", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_frame(4'b0011, 32'h00004BB4, 0, 1'b1);
        wait_idle();
        do_frame(4'b1000, 32'hC3000000, 3, 1'b1);
        wait_idle();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
